// File: rtl/jogo_pkg.sv
// Shared types and helpers for the memory-sequence game core.
// State codes are exported on db_estado, so keep them stable.
package jogo_pkg;

  localparam int ESTADO_W = 5;

  typedef enum logic [ESTADO_W-1:0] {
    INICIAL       = 5'd0,
    PREPARA       = 5'd1,
    ESPERA_NOVA   = 5'd2,
    REGISTRA_NOVA = 5'd3,
    EXIBE         = 5'd4,
    ESPERA_JOGADA = 5'd5,
    COMPARA       = 5'd6,
    FIM_GANHOU    = 5'd7,
    FIM_PERDEU    = 5'd8,
    FIM_TIMEOUT   = 5'd9
  } estado_t;

  // One-hot pattern with bit idx set; callers resize to their LED width.
  function automatic logic [31:0] one_hot(input logic [31:0] idx);
    one_hot = 32'd1 << idx;
  endfunction

  // Index of the lowest set bit (0 when nothing is set).
  function automatic logic [31:0] lowest_set_bit(input logic [31:0] v);
    lowest_set_bit = '0;
    for (int i = 31; i >= 0; i--) begin
      if (v[i]) lowest_set_bit = 32'(i);
    end
  endfunction

endpackage

// File: rtl/jogo_memoria_n_contador_m.sv
// contador_m: mod-M up counter with synchronous clear (zera), enable (conta)
// and terminal-count flag (fim, high while q == M-1). Wraps to 0 after M-1.
module contador_m #(
  parameter int M = 4,
  parameter int W = (M > 1) ? $clog2(M) : 1
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         zera,
  input  logic         conta,
  output logic [W-1:0] q,
  output logic         fim
);

  assign fim = (q == W'(M - 1));

  // Count register: reset and zera clear, conta advances modulo M.
  always_ff @(posedge clock) begin
    if (reset || zera) begin
      q <= '0;
    end else if (conta) begin
      q <= fim ? '0 : q + W'(1);
    end
  end

endmodule

// File: rtl/jogo_memoria_n.sv
// jogo_memoria_n: memory-sequence game core (control + datapath).
// Optional feature macro: TIMEOUT_EN enables the per-move timeout timer,
// the FIM_TIMEOUT state and the timeout output. Without it the ESPERA_*
// states wait indefinitely and configuracao[1] is ignored.
//
// state          | meaning
// INICIAL        | idle, all outputs low, waits for jogar
// PREPARA        | clear round/index/timers, latch configuracao
// ESPERA_NOVA    | echo buttons, wait for the new move of this round
// REGISTRA_NOVA  | store move at mem[rodada], rodada++
// EXIBE          | replay mem[0..rodada-1], T_EXIBE on + 1 blank cycle each
// ESPERA_JOGADA  | echo buttons, wait for the player's next repetition move
// COMPARA        | check move against mem[contagem]
// FIM_GANHOU     | win: pronto, ganhou, LEDs all on
// FIM_PERDEU     | loss: pronto, perdeu, LEDs off
// FIM_TIMEOUT    | timeout: pronto, timeout, LEDs off
module jogo_memoria_n
  import jogo_pkg::*;
#(
  parameter int N_BOTOES     = 4,
  parameter int PROFUNDIDADE = 16,
  parameter int T_EXIBE      = 1000,
  parameter int T_TIMEOUT    = 5000
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic                                jogar,
  input  logic [N_BOTOES-1:0]                 botoes,
  input  logic [1:0]                          configuracao,
  output logic                                ganhou,
  output logic                                perdeu,
  output logic                                timeout,
  output logic                                pronto,
  output logic [N_BOTOES-1:0]                 leds,
  output logic [ESTADO_W-1:0]                 db_estado,
  output logic [$clog2(PROFUNDIDADE+1)-1:0]   db_rodada,
  output logic [$clog2(N_BOTOES)-1:0]         db_contagem
);

  localparam int IW = $clog2(N_BOTOES);
  localparam int RW = $clog2(PROFUNDIDADE + 1);
  localparam int CW = $clog2(PROFUNDIDADE);
  localparam int EW = $clog2(T_EXIBE + 1);

  estado_t         r_estado;
  estado_t         w_prox;
  logic            r_prev;
  logic            r_move;
  logic [IW-1:0]   r_move_val;
  logic            r_cfg_replay;
  logic [IW-1:0]   r_mem [PROFUNDIDADE];

  logic [RW-1:0]   w_rodada;
  logic [CW-1:0]   w_contagem;
  logic [EW-1:0]   w_exb_q;
  logic            w_rod_fim_unused;
  logic            w_cnt_fim_unused;
  logic            w_exb_fim;
  logic            w_rod_zera, w_rod_conta;
  logic            w_cnt_zera, w_cnt_conta;
  logic            w_exb_zera, w_exb_conta;
  logic            w_rise;
  logic [IW-1:0]   w_mem_rd;
  logic            w_igual;
  logic            w_ultimo;
  logic            w_rod_cheia;
  logic            w_tmo_fim;
  logic            w_em_espera;

  assign w_rise      = (|botoes) & ~r_prev;
  assign w_mem_rd    = r_mem[w_contagem];
  assign w_igual     = (r_move_val == w_mem_rd);
  assign w_ultimo    = ((RW'(w_contagem) + RW'(1)) == w_rodada);
  assign w_rod_cheia = (w_rodada == RW'(PROFUNDIDADE - 1));
  assign w_em_espera = (r_estado == ESPERA_NOVA) || (r_estado == ESPERA_JOGADA);

  // Move detector: one-cycle pulse on the rising edge of |botoes; the value
  // is captured with the pulse so a later release cannot change it.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_prev     <= 1'b0;
      r_move     <= 1'b0;
      r_move_val <= '0;
    end else begin
      r_prev <= |botoes;
      r_move <= w_rise;
      if (w_rise) r_move_val <= IW'(lowest_set_bit(32'(botoes)));
    end
  end

  // Sequence memory: written only while registering a new move, never cleared.
  always_ff @(posedge clock) begin
    if (r_estado == REGISTRA_NOVA) r_mem[w_rodada[CW-1:0]] <= r_move_val;
  end

  contador_m #(.M(PROFUNDIDADE + 1), .W(RW)) u_rodada (
    .clock (clock), .reset (reset), .zera (w_rod_zera), .conta (w_rod_conta),
    .q     (w_rodada), .fim (w_rod_fim_unused)
  );

  contador_m #(.M(PROFUNDIDADE), .W(CW)) u_contagem (
    .clock (clock), .reset (reset), .zera (w_cnt_zera), .conta (w_cnt_conta),
    .q     (w_contagem), .fim (w_cnt_fim_unused)
  );

  contador_m #(.M(T_EXIBE + 1), .W(EW)) u_exibe (
    .clock (clock), .reset (reset), .zera (w_exb_zera), .conta (w_exb_conta),
    .q     (w_exb_q), .fim (w_exb_fim)
  );

`ifdef TIMEOUT_EN
  localparam int TW = $clog2(T_TIMEOUT);
  logic            r_cfg_tmo;
  logic [TW-1:0]   w_tmo_q_unused;
  logic            w_tmo_raw;

  // The timer restarts whenever we are outside ESPERA_* or a move arrives,
  // so it is already zero on every ESPERA_* entry.
  contador_m #(.M(T_TIMEOUT), .W(TW)) u_timeout (
    .clock (clock), .reset (reset),
    .zera  (~w_em_espera | r_move), .conta (w_em_espera & r_cfg_tmo),
    .q     (w_tmo_q_unused), .fim (w_tmo_raw)
  );

  assign w_tmo_fim = w_tmo_raw & w_em_espera & r_cfg_tmo;
  assign timeout   = (r_estado == FIM_TIMEOUT);

  // Timeout enable is latched at game start.
  always_ff @(posedge clock) begin
    if (reset) r_cfg_tmo <= 1'b0;
    else if (r_estado == PREPARA) r_cfg_tmo <= configuracao[1];
  end
`else
  logic w_cfg_tmo_unused;
  assign w_cfg_tmo_unused = configuracao[1];
  assign w_tmo_fim        = 1'b0;
  assign timeout          = 1'b0;
`endif

  // Replay enable is latched at game start.
  always_ff @(posedge clock) begin
    if (reset) r_cfg_replay <= 1'b0;
    else if (r_estado == PREPARA) r_cfg_replay <= configuracao[0];
  end

  // State register.
  always_ff @(posedge clock) begin
    if (reset) r_estado <= INICIAL;
    else       r_estado <= w_prox;
  end

  // Next-state and counter controls; a move takes priority over timer expiry.
  always_comb begin
    w_prox      = r_estado;
    w_rod_zera  = 1'b0;
    w_rod_conta = 1'b0;
    w_cnt_zera  = 1'b0;
    w_cnt_conta = 1'b0;
    w_exb_zera  = 1'b0;
    w_exb_conta = 1'b0;
    case (r_estado)
      INICIAL: if (jogar) w_prox = PREPARA;
      PREPARA: begin
        w_rod_zera = 1'b1;
        w_cnt_zera = 1'b1;
        w_exb_zera = 1'b1;
        w_prox     = ESPERA_NOVA;
      end
      ESPERA_NOVA: begin
        if (r_move)         w_prox = REGISTRA_NOVA;
        else if (w_tmo_fim) w_prox = FIM_TIMEOUT;
      end
      REGISTRA_NOVA: begin
        w_rod_conta = 1'b1;
        w_cnt_zera  = 1'b1;
        w_exb_zera  = 1'b1;
        if (w_rod_cheia)       w_prox = FIM_GANHOU;
        else if (r_cfg_replay) w_prox = EXIBE;
        else                   w_prox = ESPERA_JOGADA;
      end
      EXIBE: begin
        w_exb_conta = 1'b1;
        if (w_exb_fim) begin
          if (w_ultimo) begin
            w_cnt_zera = 1'b1;
            w_prox     = ESPERA_JOGADA;
          end else begin
            w_cnt_conta = 1'b1;
          end
        end
      end
      ESPERA_JOGADA: begin
        if (r_move)         w_prox = COMPARA;
        else if (w_tmo_fim) w_prox = FIM_TIMEOUT;
      end
      COMPARA: begin
        if (!w_igual)      w_prox = FIM_PERDEU;
        else if (w_ultimo) w_prox = ESPERA_NOVA;
        else begin
          w_cnt_conta = 1'b1;
          w_prox      = ESPERA_JOGADA;
        end
      end
      FIM_GANHOU, FIM_PERDEU, FIM_TIMEOUT: if (jogar) w_prox = PREPARA;
      default: w_prox = INICIAL;
    endcase
  end

  // LED decode: echo while waiting, replay pattern with a blank tail, all on for a win.
  always_comb begin
    leds = '0;
    case (r_estado)
      ESPERA_NOVA, ESPERA_JOGADA: leds = botoes;
      EXIBE:      if (!w_exb_fim) leds = N_BOTOES'(one_hot(32'(w_mem_rd)));
      FIM_GANHOU: leds = '1;
      default:    leds = '0;
    endcase
  end

  assign ganhou      = (r_estado == FIM_GANHOU);
  assign perdeu      = (r_estado == FIM_PERDEU);
  assign pronto      = (r_estado == FIM_GANHOU) || (r_estado == FIM_PERDEU) ||
                       (r_estado == FIM_TIMEOUT);
  assign db_estado   = r_estado;
  assign db_rodada   = w_rodada;
  assign db_contagem = IW'(w_contagem);

endmodule
